// File: rtl/branch_redirect_ctrl_if.sv
// Branch redirect controller bundle: resolution/hazard inputs, PC/flush controls,
// statistics and a debug view of the FSM state.
interface branch_redirect_ctrl_if #(
    parameter int N            = 64,
    parameter int FLUSH_STAGES = 3,
    parameter int CNT_W        = 16
);
    logic                    resolve_valid;
    logic                    PCSrc_W;
    logic [N-1:0]            target_W;
    logic                    stall_req;
    logic                    imem_busy;
    logic                    pc_load;
    logic [N-1:0]            pc_target;
    logic                    pc_hold;
    logic [FLUSH_STAGES-1:0] flush;
    logic                    redirect_pending;
    logic                    err;
    logic [CNT_W-1:0]        branch_count;
    logic [CNT_W-1:0]        taken_count;
    logic                    fsm_state;  // 0 = RUN, 1 = WAIT_IMEM

    // Handshake: no valid/ready pair here. resolve_valid qualifies PCSrc_W and
    // target_W for one cycle; imem_busy=1 blocks pc_load for as long as it stays high.
    modport master (
        output resolve_valid, PCSrc_W, target_W, stall_req, imem_busy,
        input  pc_load, pc_target, pc_hold, flush, redirect_pending, err,
               branch_count, taken_count, fsm_state
    );
    modport slave (
        input  resolve_valid, PCSrc_W, target_W, stall_req, imem_busy,
        output pc_load, pc_target, pc_hold, flush, redirect_pending, err,
               branch_count, taken_count, fsm_state
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Turns resolved taken branches into PC-load/hold and per-stage flush controls,
// deferring the redirect while a fetch is outstanding; keeps branch statistics.
module branch_redirect_ctrl #(
    parameter int N            = 64,
    parameter int FLUSH_STAGES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_redirect_ctrl_if.slave bus
);
    typedef enum logic {RUN = 1'b0, WAIT_IMEM = 1'b1} state_t;

    localparam logic [FLUSH_STAGES-1:0] FLUSH_IFID = FLUSH_STAGES'(1);
    localparam logic [FLUSH_STAGES-1:0] FLUSH_IDEX = FLUSH_STAGES'(2);
    localparam logic [FLUSH_STAGES-1:0] FLUSH_ALL  = '1;

    state_t                  state_q, state_d;
    logic [N-1:0]            target_q, target_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        branch_q, branch_d;
    logic [CNT_W-1:0]        taken_q, taken_d;

    logic                    pc_load, pc_hold, pending;
    logic [FLUSH_STAGES-1:0] flush;
    logic [N-1:0]            load_tgt;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        err_d    = err_q;
        branch_d = branch_q;
        taken_d  = taken_q;
        pc_load  = 1'b0;
        pc_hold  = 1'b0;
        pending  = 1'b0;
        flush    = '0;
        load_tgt = target_q;
        case (state_q)
            RUN: begin
                if (bus.resolve_valid) begin
                    if (branch_q != '1) branch_d = branch_q + CNT_W'(1);
                    if (bus.PCSrc_W && taken_q != '1) taken_d = taken_q + CNT_W'(1);
                end
                // The resolving branch is older than the load-use pair, so it wins.
                if (bus.resolve_valid && bus.PCSrc_W) begin
                    flush = FLUSH_ALL;
                    if (!bus.imem_busy) begin
                        pc_load  = 1'b1;
                        load_tgt = bus.target_W;
                    end else begin
                        target_d = bus.target_W;
                        pc_hold  = 1'b1;
                        state_d  = WAIT_IMEM;
                    end
                end else if (bus.stall_req) begin
                    pc_hold = 1'b1;
                    flush   = FLUSH_IDEX;
                end
            end
            WAIT_IMEM: begin
                pending = 1'b1;
                // Discard whatever stale fetch lands in IF/ID while we wait.
                flush   = FLUSH_IFID;
                if (bus.resolve_valid) err_d = 1'b1;
                if (!bus.imem_busy) begin
                    pc_load = 1'b1;
                    state_d = RUN;
                end else begin
                    pc_hold = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            target_q <= '0;
            err_q    <= 1'b0;
            branch_q <= '0;
            taken_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            err_q    <= err_d;
            branch_q <= branch_d;
            taken_q  <= taken_d;
        end
    end

    // Controls are forced quiet during reset even if the inputs are active.
    assign bus.pc_load          = pc_load & ~reset;
    assign bus.pc_hold          = pc_hold & ~reset;
    assign bus.redirect_pending = pending & ~reset;
    assign bus.flush            = reset ? '0 : flush;
    assign bus.pc_target        = reset ? '0 : load_tgt;
    assign bus.err              = err_q;
    assign bus.branch_count     = branch_q;
    assign bus.taken_count      = taken_q;
    assign bus.fsm_state        = (state_q == WAIT_IMEM);
endmodule
